// File: rtl/obq_ctrl.sv
// obq_ctrl: branch-history queue controller with shadow pointers, recovery stall FSM and retire FIFO.
// All queue commands are registered; fetch_grant, busy and retire_ready are combinational.
module obq_ctrl #(
    parameter int OBQ_SIZE = 16,
    parameter int BH_W = 8,
    parameter int RCV_CYC = 2,
    parameter int RQ_DEPTH = 4,
    localparam int IW = $clog2(OBQ_SIZE)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            fetch_req_i,
    input  logic [BH_W-1:0] fetch_row_i,
    output logic            fetch_grant_o,
    output logic [IW-1:0]   fetch_tag_o,
    input  logic            mispred_valid_i,
    input  logic [IW-1:0]   mispred_tag_i,
    input  logic            retire_valid_i,
    input  logic [IW-1:0]   retire_tag_i,
    output logic            retire_ready_o,
    output logic            obq_write_en_o,
    output logic [BH_W-1:0] obq_bh_row_o,
    output logic            obq_clear_en_o,
    output logic [IW-1:0]   obq_index_o,
    output logic            obq_shift_en_o,
    output logic [IW-1:0]   obq_shift_index_o,
    output logic            busy_o,
    output logic [IW:0]     live_count_o,
    output logic            drop_err_o
);
    localparam int RW = $clog2(RQ_DEPTH);
    typedef enum logic {IDLE, RECOVER} state_e;
    state_e state_q, state_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic [IW-1:0] head_q, head_d, tail_q, tail_d;
    logic [IW:0] live_q, live_d;
    logic [IW-1:0] rq_mem_q [RQ_DEPTH];
    logic [RW-1:0] rd_q, wr_q;
    logic [RW:0] cnt_q;
    logic [IW-1:0] m_off, r_off, r_tag;
    logic m_in, r_in, pop, push, shift;
    logic write_en_q, clear_en_q, shift_en_q, drop_err_q;
    logic [BH_W-1:0] bh_row_q;
    logic [IW-1:0] index_q, shift_index_q;
    // A tag is live when its distance from head (mod OBQ_SIZE) is below live_count.
    assign m_off = mispred_tag_i - head_q;
    assign m_in = {1'b0, m_off} < live_q;
    assign r_tag = rq_mem_q[rd_q];
    assign r_off = r_tag - head_q;
    assign r_in = {1'b0, r_off} < live_q;
    assign pop = (cnt_q != '0) & ~mispred_valid_i;
    assign shift = pop & r_in;
    assign retire_ready_o = cnt_q != (RW+1)'(RQ_DEPTH);
    assign push = retire_valid_i & retire_ready_o;
    assign busy_o = state_q == RECOVER;
    assign fetch_grant_o = (state_q == IDLE) & fetch_req_i & (live_q < (IW+1)'(OBQ_SIZE-1)) & ~mispred_valid_i;
    assign fetch_tag_o = tail_q;
    assign live_count_o = live_q;
    assign obq_write_en_o = write_en_q;
    assign obq_bh_row_o = bh_row_q;
    assign obq_clear_en_o = clear_en_q;
    assign obq_index_o = index_q;
    assign obq_shift_en_o = shift_en_q;
    assign obq_shift_index_o = shift_index_q;
    assign drop_err_o = drop_err_q;
    always_comb begin
        state_d = (state_q == RECOVER && rcnt_q == 4'd1) ? IDLE : state_q;
        rcnt_d = (rcnt_q == '0) ? '0 : rcnt_q - 4'd1;
        if (mispred_valid_i) begin
            state_d = RECOVER;
            rcnt_d = 4'(RCV_CYC);
        end
        head_d = shift ? r_tag + 1'b1 : head_q;
        tail_d = (mispred_valid_i & m_in) ? mispred_tag_i : tail_q + IW'(fetch_grant_o);
        live_d = (mispred_valid_i & m_in) ? {1'b0, m_off}
               : live_q + (IW+1)'(fetch_grant_o) - (shift ? {1'b0, r_off} + 1'b1 : '0);
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rcnt_q <= '0;
            head_q <= '0;
            tail_q <= '0;
            live_q <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
            write_en_q <= 1'b0;
            bh_row_q <= '0;
            clear_en_q <= 1'b0;
            index_q <= '0;
            shift_en_q <= 1'b0;
            shift_index_q <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q <= rcnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            live_q <= live_d;
            rd_q <= rd_q + RW'(pop);
            wr_q <= wr_q + RW'(push);
            cnt_q <= cnt_q + (RW+1)'(push) - (RW+1)'(pop);
            write_en_q <= fetch_grant_o;
            bh_row_q <= fetch_row_i;
            clear_en_q <= mispred_valid_i & m_in;
            index_q <= mispred_tag_i;
            shift_en_q <= shift;
            shift_index_q <= r_tag;
            drop_err_q <= drop_err_q | (pop & ~r_in);
        end
    end
    always_ff @(posedge clock_i) begin
        if (push) rq_mem_q[wr_q] <= retire_tag_i;
    end
endmodule

// File: tb/tb_obq_ctrl.sv
// tb_obq_ctrl: table vectors, directed corner sequences and random traffic against a list-based model.
module tb_obq_ctrl;
    localparam int N = 16;
    localparam int BW = 8;
    localparam int RCV = 2;
    localparam int RQD = 4;
    localparam int IW = $clog2(N);
    logic clock_i = 0;
    logic reset_i = 1;
    logic fetch_req_i = 0;
    logic [BW-1:0] fetch_row_i = '0;
    logic fetch_grant_o;
    logic [IW-1:0] fetch_tag_o;
    logic mispred_valid_i = 0;
    logic [IW-1:0] mispred_tag_i = '0;
    logic retire_valid_i = 0;
    logic [IW-1:0] retire_tag_i = '0;
    logic retire_ready_o;
    logic obq_write_en_o, obq_clear_en_o, obq_shift_en_o;
    logic [BW-1:0] obq_bh_row_o;
    logic [IW-1:0] obq_index_o, obq_shift_index_o;
    logic busy_o, drop_err_o;
    logic [IW:0] live_count_o;
    obq_ctrl #(.OBQ_SIZE(N), .BH_W(BW), .RCV_CYC(RCV), .RQ_DEPTH(RQD)) dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .fetch_req_i(fetch_req_i), .fetch_row_i(fetch_row_i),
        .fetch_grant_o(fetch_grant_o), .fetch_tag_o(fetch_tag_o),
        .mispred_valid_i(mispred_valid_i), .mispred_tag_i(mispred_tag_i),
        .retire_valid_i(retire_valid_i), .retire_tag_i(retire_tag_i),
        .retire_ready_o(retire_ready_o),
        .obq_write_en_o(obq_write_en_o), .obq_bh_row_o(obq_bh_row_o),
        .obq_clear_en_o(obq_clear_en_o), .obq_index_o(obq_index_o),
        .obq_shift_en_o(obq_shift_en_o), .obq_shift_index_o(obq_shift_index_o),
        .busy_o(busy_o), .live_count_o(live_count_o), .drop_err_o(drop_err_o)
    );
    always #5 clock_i = ~clock_i;

    int checks = 0;
    int errors = 0;
    // Model: the ordered list of live tags, the next tag to hand out, remaining stall cycles, retire FIFO.
    int lst[$];
    int fq[$];
    int tl = 0;
    int rem = 0;
    bit drp = 0;
    bit e_we, e_ce, e_se;
    int e_row, e_idx, e_sidx;
    bit g_seen, r_seen;

    typedef struct {
        bit fr; bit mv; int mt; bit rv; int rt;
        bit eg; int etag; int elive; bit ebusy; bit edrop;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int find_tag(input int t);
        for (int i = 0; i < lst.size(); i++) if (lst[i] == t) return i;
        return -1;
    endfunction

    task automatic idle_inputs();
        fetch_req_i = 0;
        mispred_valid_i = 0;
        retire_valid_i = 0;
    endtask

    task automatic step();
        bit g, rdy;
        int idx, t;
        #1;
        g = (rem == 0) && fetch_req_i && (lst.size() < N - 1) && !mispred_valid_i;
        rdy = fq.size() < RQD;
        chk("grant", int'(fetch_grant_o), int'(g));
        if (g) chk("fetch_tag", int'(fetch_tag_o), tl);
        chk("retire_ready", int'(retire_ready_o), int'(rdy));
        chk("busy", int'(busy_o), int'(rem > 0));
        chk("live_count", int'(live_count_o), lst.size());
        g_seen = fetch_grant_o;
        r_seen = retire_ready_o;
        e_we = g;
        e_row = int'(fetch_row_i);
        e_ce = 0;
        e_se = 0;
        if (mispred_valid_i) begin
            idx = find_tag(int'(mispred_tag_i));
            if (idx >= 0) begin
                e_ce = 1;
                e_idx = int'(mispred_tag_i);
                while (lst.size() > idx) void'(lst.pop_back());
                tl = int'(mispred_tag_i);
            end
            rem = RCV;
        end else begin
            if (rem > 0) rem--;
            if (fq.size() > 0) begin
                t = fq.pop_front();
                idx = find_tag(t);
                if (idx >= 0) begin
                    e_se = 1;
                    e_sidx = t;
                    repeat (idx + 1) void'(lst.pop_front());
                end else drp = 1;
            end
        end
        if (g) begin
            lst.push_back(tl);
            tl = (tl + 1) % N;
        end
        if (retire_valid_i && rdy) fq.push_back(int'(retire_tag_i));
        @(posedge clock_i);
        #1;
        chk("write_en", int'(obq_write_en_o), int'(e_we));
        if (e_we) chk("bh_row", int'(obq_bh_row_o), e_row);
        chk("clear_en", int'(obq_clear_en_o), int'(e_ce));
        if (e_ce) chk("clear_index", int'(obq_index_o), e_idx);
        chk("shift_en", int'(obq_shift_en_o), int'(e_se));
        if (e_se) chk("shift_index", int'(obq_shift_index_o), e_sidx);
        chk("drop_err", int'(drop_err_o), int'(drp));
    endtask

    task automatic do_reset();
        reset_i = 1;
        idle_inputs();
        @(posedge clock_i);
        #1;
        chk("rst_write_en", int'(obq_write_en_o), 0);
        chk("rst_clear_en", int'(obq_clear_en_o), 0);
        chk("rst_shift_en", int'(obq_shift_en_o), 0);
        chk("rst_drop_err", int'(drop_err_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_live", int'(live_count_o), 0);
        chk("rst_ready", int'(retire_ready_o), 1);
        chk("rst_grant", int'(fetch_grant_o), 0);
        reset_i = 0;
        lst.delete();
        fq.delete();
        tl = 0;
        rem = 0;
        drp = 0;
    endtask

    task automatic fetch_n(input int n);
        repeat (n) begin
            fetch_req_i = 1;
            fetch_row_i = BW'($urandom);
            step();
        end
        fetch_req_i = 0;
    endtask

    initial begin
        int grants, nexp, nsh;
        // Grants 0..4, mispredict at tag 2, stall, regrant tag 2, retire 0, retire out of range.
        vt.push_back('{1,0,0,0,0, 1,0,0,0,0});
        vt.push_back('{1,0,0,0,0, 1,1,1,0,0});
        vt.push_back('{1,0,0,0,0, 1,2,2,0,0});
        vt.push_back('{1,0,0,0,0, 1,3,3,0,0});
        vt.push_back('{1,0,0,0,0, 1,4,4,0,0});
        vt.push_back('{0,1,2,0,0, 0,0,5,0,0});
        vt.push_back('{1,0,0,0,0, 0,0,2,1,0});
        vt.push_back('{1,0,0,0,0, 0,0,2,1,0});
        vt.push_back('{1,0,0,0,0, 1,2,2,0,0});
        vt.push_back('{0,0,0,1,0, 0,0,3,0,0});
        vt.push_back('{0,0,0,0,0, 0,0,3,0,0});
        vt.push_back('{0,0,0,0,0, 0,0,2,0,0});
        vt.push_back('{0,0,0,1,9, 0,0,2,0,0});
        vt.push_back('{0,0,0,0,0, 0,0,2,0,0});
        vt.push_back('{0,0,0,0,0, 0,0,2,0,1});
        vt.push_back('{0,0,0,0,0, 0,0,2,0,1});
        @(posedge clock_i);
        #1;
        do_reset();
        for (int i = 0; i < vt.size(); i++) begin
            fetch_req_i = vt[i].fr;
            fetch_row_i = BW'(i * 17 + 3);
            mispred_valid_i = vt[i].mv;
            mispred_tag_i = IW'(vt[i].mt);
            retire_valid_i = vt[i].rv;
            retire_tag_i = IW'(vt[i].rt);
            #1;
            chk($sformatf("vec%0d_grant", i), int'(fetch_grant_o), int'(vt[i].eg));
            if (vt[i].eg) chk($sformatf("vec%0d_tag", i), int'(fetch_tag_o), vt[i].etag);
            chk($sformatf("vec%0d_live", i), int'(live_count_o), vt[i].elive);
            chk($sformatf("vec%0d_busy", i), int'(busy_o), int'(vt[i].ebusy));
            chk($sformatf("vec%0d_drop", i), int'(drop_err_o), int'(vt[i].edrop));
            step();
        end
        idle_inputs();
        // Fill: 20 requests yield exactly 15 grants.
        do_reset();
        grants = 0;
        repeat (20) begin
            fetch_req_i = 1;
            step();
            grants += int'(g_seen);
        end
        fetch_req_i = 0;
        chk("fill_grants", grants, N - 1);
        chk("fill_live", int'(live_count_o), N - 1);
        fetch_req_i = 1;
        #1;
        chk("fill_no_grant", int'(fetch_grant_o), 0);
        fetch_req_i = 0;
        // Wrapped range: head=14, tail=3, retire tag 1.
        do_reset();
        fetch_n(14);
        retire_valid_i = 1;
        retire_tag_i = 13;
        step();
        retire_valid_i = 0;
        step();
        step();
        fetch_n(5);
        retire_valid_i = 1;
        retire_tag_i = 1;
        step();
        retire_valid_i = 0;
        step();
        chk("wrap_shift_en", int'(obq_shift_en_o), 1);
        chk("wrap_shift_index", int'(obq_shift_index_o), 1);
        chk("wrap_live", int'(live_count_o), 1);
        // Five retires while clears are decided: fifth refused, four shifts follow in order.
        do_reset();
        fetch_n(8);
        for (int k = 0; k < 5; k++) begin
            mispred_valid_i = 1;
            mispred_tag_i = 7;
            retire_valid_i = 1;
            retire_tag_i = IW'(k);
            step();
            if (k == 4) chk("rq_full_ready", int'(r_seen), 0);
        end
        idle_inputs();
        nexp = 0;
        nsh = 0;
        repeat (6) begin
            step();
            if (obq_shift_en_o) begin
                chk("rq_shift_order", int'(obq_shift_index_o), nexp);
                nexp++;
                nsh++;
            end
        end
        chk("rq_shift_count", nsh, 4);
        // Reset mid-RECOVER with two buffered retires.
        do_reset();
        fetch_n(6);
        mispred_valid_i = 1;
        mispred_tag_i = 5;
        retire_valid_i = 1;
        retire_tag_i = 0;
        step();
        retire_tag_i = 1;
        step();
        idle_inputs();
        chk("pre_rst_busy", int'(busy_o), 1);
        do_reset();
        fetch_n(1);
        step();
        // Random traffic with occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            fetch_req_i = $urandom_range(0, 9) < 7;
            fetch_row_i = BW'($urandom);
            mispred_valid_i = $urandom_range(0, 19) == 0;
            mispred_tag_i = IW'($urandom_range(0, N - 1));
            retire_valid_i = $urandom_range(0, 9) < 4;
            if (lst.size() > 0 && $urandom_range(0, 3) != 0)
                retire_tag_i = IW'(lst[$urandom_range(0, lst.size() - 1)]);
            else
                retire_tag_i = IW'($urandom_range(0, N - 1));
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
